// File: rtl/coding_queue_mc.sv
// Multi-channel context bit queue: per-channel circular bit FIFOs feeding one
// registered output, with round-robin arbitration between non-empty channels.
module coding_queue_mc #(
  parameter int CHANNELS     = 4,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_MARGIN = 2,
  localparam int CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_bit,
  input  logic [CHW-1:0]      in_ch,
  input  logic                in_wrreq,
  output logic [CHANNELS-1:0] ch_afull,
  output logic [CHANNELS-1:0] ch_empty,
  output logic [CHANNELS-1:0] ch_ovf,
  output logic                out_bit,
  output logic [CHW-1:0]      out_ctx,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [DEPTH-1:0]      mem    [CHANNELS];
  logic [DEPTH_LOG2-1:0] wr_ptr [CHANNELS];
  logic [DEPTH_LOG2-1:0] rd_ptr [CHANNELS];
  logic [CW-1:0]         count  [CHANNELS];
  logic [CHW-1:0]        last_grant;
  logic [CHW-1:0]        winner;
  logic [CHW-1:0]        cand;
  logic                  any_ne;
  logic                  load_en;
  logic                  pop;
  logic                  wr_valid;
  logic [CHANNELS-1:0]   full;
  logic [CHANNELS-1:0]   wr_sel;
  logic [CHANNELS-1:0]   drop_sel;
  logic [CHANNELS-1:0]   pop_sel;

  // Round-robin search: scanning from the farthest candidate back to the
  // nearest lets the nearest non-empty channel after last_grant win.
  always_comb begin
    winner = '0;
    cand   = '0;
    any_ne = 1'b0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand = CHW'((int'(last_grant) + k) % CHANNELS);
      if (count[cand] != '0) begin
        winner = cand;
        any_ne = 1'b1;
      end
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign pop      = load_en && any_ne;
  assign wr_valid = in_wrreq && (int'(in_ch) < CHANNELS);

  always_comb begin
    full     = '0;
    wr_sel   = '0;
    drop_sel = '0;
    pop_sel  = '0;
    ch_empty = '0;
    ch_afull = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      full[i]     = (count[i] == CW'(DEPTH));
      wr_sel[i]   = wr_valid && (in_ch == CHW'(i)) && !full[i];
      drop_sel[i] = wr_valid && (in_ch == CHW'(i)) && full[i];
      pop_sel[i]  = pop && (winner == CHW'(i));
      ch_empty[i] = (count[i] == '0);
      ch_afull[i] = (count[i] >= CW'(DEPTH - AFULL_MARGIN));
    end
  end

  // Bit storage: written only, never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_sel[i]) mem[i][wr_ptr[i]] <= in_bit;
    end
  end

  // Queue control and output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ch_ovf     <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_ctx    <= '0;
      last_grant <= CHW'(CHANNELS - 1);
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_sel[i])   wr_ptr[i] <= wr_ptr[i] + DEPTH_LOG2'(1);
        if (pop_sel[i])  rd_ptr[i] <= rd_ptr[i] + DEPTH_LOG2'(1);
        if (wr_sel[i] && !pop_sel[i])      count[i] <= count[i] + CW'(1);
        else if (!wr_sel[i] && pop_sel[i]) count[i] <= count[i] - CW'(1);
        if (drop_sel[i]) ch_ovf[i] <= 1'b1;
      end
      if (load_en) begin
        if (any_ne) begin
          out_bit    <= mem[winner][rd_ptr[winner]];
          out_ctx    <= winner;
          out_valid  <= 1'b1;
          last_grant <= winner;
        end else begin
          out_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_coding_queue_mc.sv
// Bench for coding_queue_mc: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_coding_queue_mc;

  localparam int CH    = 4;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
  localparam int CHW   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_bit = 1'b0;
  logic [CHW-1:0] in_ch = '0;
  logic           in_wrreq = 1'b0;
  logic [CH-1:0]  ch_afull, ch_empty, ch_ovf;
  logic           out_bit;
  logic [CHW-1:0] out_ctx;
  logic           out_valid;
  logic           out_ready = 1'b0;

  coding_queue_mc #(.CHANNELS(CH), .DEPTH_LOG2(DL2), .AFULL_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_ch(in_ch), .in_wrreq(in_wrreq),
    .ch_afull(ch_afull), .ch_empty(ch_empty), .ch_ovf(ch_ovf),
    .out_bit(out_bit), .out_ctx(out_ctx), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  bit          mq [CH][$];
  bit [CH-1:0] m_ovf;
  bit          m_valid, m_bit;
  int          m_ctx, m_lg;
  int          vectors = 0;
  int          miscompares = 0;
  bit          pat [17];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: one clock edge applied to per-channel queues.
  task automatic model_edge(input bit r, input bit wr, input int ch, input bit b, input bit rdy);
    int w;
    bit load, full_pre;
    if (r) begin
      for (int i = 0; i < CH; i++) mq[i].delete();
      m_ovf = '0; m_valid = 0; m_bit = 0; m_ctx = 0; m_lg = CH - 1;
      return;
    end
    w = -1;
    load = !m_valid || rdy;
    for (int k = 1; k <= CH; k++) begin
      if (w < 0 && mq[(m_lg + k) % CH].size() > 0) w = (m_lg + k) % CH;
    end
    full_pre = (wr && ch < CH) ? (mq[ch].size() == DEPTH) : 1'b0;
    if (load) begin
      if (w >= 0) begin
        m_bit = mq[w].pop_front(); m_ctx = w; m_valid = 1; m_lg = w;
      end else m_valid = 0;
    end
    if (wr && ch < CH) begin
      if (full_pre) m_ovf[ch] = 1'b1;
      else mq[ch].push_back(b);
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] e_empty, e_afull;
    for (int i = 0; i < CH; i++) begin
      e_empty[i] = (mq[i].size() == 0);
      e_afull[i] = (mq[i].size() >= DEPTH - AFM);
    end
    check("model_empty", ch_empty, e_empty);
    check("model_afull", ch_afull, e_afull);
    check("model_ovf", ch_ovf, m_ovf);
    check("model_valid", out_valid, m_valid);
    check("model_bit", out_bit, m_bit);
    check("model_ctx", out_ctx, m_ctx);
  endtask

  task automatic step(input bit r, input bit wr, input int ch, input bit b, input bit rdy);
    rst = r; in_wrreq = wr; in_ch = CHW'(ch); in_bit = b; out_ready = rdy;
    @(posedge clk);
    model_edge(r, wr, ch, b, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(1, 1, 1, 1, 1);
    do_reset();
    check("rst_empty", ch_empty, 4'hF);
    check("rst_afull", ch_afull, 4'h0);
    check("rst_ovf", ch_ovf, 4'h0);
    check("rst_valid", out_valid, 1'b0);

    // Three bits through ch2 with latency 2
    step(0, 1, 2, 1, 1);
    check("lat_c0_valid", out_valid, 1'b0);
    step(0, 1, 2, 0, 1);
    check("lat_c1_valid", out_valid, 1'b1);
    check("lat_c1_ctx", out_ctx, 2);
    check("lat_c1_bit", out_bit, 1'b1);
    step(0, 1, 2, 1, 1);
    check("seq_bit1", out_bit, 1'b0);
    step(0, 0, 0, 0, 1);
    check("seq_bit2", out_bit, 1'b1);
    step(0, 0, 0, 0, 1);
    check("drained_empty2", ch_empty[2], 1'b1);
    check("drained_valid", out_valid, 1'b0);

    // Round-robin from reset: 0,1,2,3
    do_reset();
    for (int c = 0; c < CH; c++) step(0, 1, c, c[0], 0);
    check("rr_a0", out_ctx, 0);
    for (int c = 1; c < CH; c++) begin
      step(0, 0, 0, 0, 1);
      check("rr_a_seq", out_ctx, c);
    end
    step(0, 0, 0, 0, 1);
    check("rr_a_end", out_valid, 1'b0);

    // Round-robin with last_grant=1: 2,3,0,1
    do_reset();
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    check("rr_b_hold", out_ctx, 1);
    for (int c = 1; c < CH; c++) step(0, 1, c, 1, 0);
    step(0, 0, 0, 0, 1); check("rr_b_2", out_ctx, 2);
    step(0, 0, 0, 0, 1); check("rr_b_3", out_ctx, 3);
    step(0, 0, 0, 0, 1); check("rr_b_0", out_ctx, 0);
    step(0, 0, 0, 0, 1); check("rr_b_1", out_ctx, 1);

    // Fill ch1 past full while output is stalled
    do_reset();
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    for (int j = 0; j < 17; j++) begin
      pat[j] = 1'($urandom);
      step(0, 1, 1, pat[j], 0);
      if (j == 12) check("afull_at13", ch_afull[1], 1'b0);
      if (j == 13) check("afull_at14", ch_afull[1], 1'b1);
    end
    check("ovf_ch1", ch_ovf, 4'b0010);
    check("stall_ctx", out_ctx, 0);
    check("stall_bit", out_bit, 1'b1);
    check("stall_valid", out_valid, 1'b1);
    for (int j = 0; j < 16; j++) begin
      step(0, 0, 0, 0, 1);
      check("drain_bit", out_bit, pat[j]);
      check("drain_ctx", out_ctx, 1);
    end
    step(0, 0, 0, 0, 1);
    check("drain_done", out_valid, 1'b0);

    // Full ch3 with simultaneous write and pop
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) step(0, 1, 3, j[0], 0);
    check("full3_afull", ch_afull[3], 1'b1);
    check("full3_noovf", ch_ovf, 4'b0000);
    step(0, 1, 3, 1, 1);
    check("full3_ovf", ch_ovf, 4'b1000);
    check("full3_ctx", out_ctx, 3);
    for (int j = 0; j < 3; j++) step(0, 1, 3, 0, 1);
    check("part3_afull", ch_afull[3], 1'b1);

    // Reset mid-operation, then latency from reset
    do_reset();
    for (int c = 0; c < CH; c++) step(0, 1, c, 1, 0);
    check("pre_rst_valid", out_valid, 1'b1);
    step(1, 1, 0, 1, 1);
    check("mid_rst_empty", ch_empty, 4'hF);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_bit", out_bit, 1'b0);
    check("mid_rst_ctx", out_ctx, 0);
    step(0, 1, 0, 1, 1);
    check("post_rst_n1", out_valid, 1'b0);
    step(0, 0, 0, 0, 1);
    check("post_rst_n2", out_valid, 1'b1);
    check("post_rst_bit", out_bit, 1'b1);

    // Random traffic with varying backpressure
    for (int n = 0; n < 1200; n++) begin
      bit r, wr, rdy;
      r   = ($urandom_range(0, 199) == 0);
      wr  = ($urandom_range(0, 9) < 7);
      rdy = (n % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(r, wr, $urandom_range(0, CH - 1), 1'($urandom), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
